// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit and HI/LO register pair.
//
// Executes MULT/MULTU (shift-add, 32 cycles) and DIV/DIVU (restoring, 32 cycles)
// and holds the 64-bit {HI, LO} state. MTHI/MTLO results from the ALU are written
// through hilo_we while no operation is in flight.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   defined   - MULT/MULTU finish in one cycle with a combinational 64-bit product.
//   undefined - multiplies use the 32-cycle iterative datapath.
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   launch an operation (sampled only when busy = 0)
//   op[1:0]     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[31:0]     in   rs operand (multiplicand / dividend)
//   b[31:0]     in   rt operand (multiplier / divisor)
//   cancel      in   pipeline flush, aborts the in-flight operation
//   hilo_we     in   direct {HI, LO} write
//   hilo_wdata  in   value for the direct write, {HI, LO}
//   busy        out  operation in flight
//   done        out  one-cycle pulse, hilo holds a new mul/div result
//   hilo[63:0]  out  current {HI, LO}

module mdu_hilo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hilo_we,
  input  logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] hilo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state;
  logic [4:0]  cnt;
  logic [63:0] acc;       // MUL: {partial sum, multiplier}; DIV: {remainder, quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic        neg_lo;    // product / quotient sign
  logic        neg_hi;    // remainder sign
  logic        div_zero;

  // Operand magnitudes; op[0] = 0 selects the signed variants.
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign abs_a     = a_neg ? (~a + 32'd1) : a;
  assign abs_b     = b_neg ? (~b + 32'd1) : b;

  // Shift-add step: 33-bit add into the upper half keeps the carry, then shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign mul_res  = neg_lo ? (~mul_next + 64'd1) : mul_next;

  // Restoring step: acc[63:31] is the upper 33 bits of the left-shifted register.
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
  assign div_next = div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
  assign quo_res  = neg_lo ? (~div_next[31:0] + 32'd1) : div_next[31:0];
  assign rem_res  = neg_hi ? (~div_next[63:32] + 32'd1) : div_next[63:32];

  // Single-cycle multiply path. Low 64 bits of the product of the sign- or
  // zero-extended operands equal the signed or unsigned 64-bit product.
  logic        fast_mul;
  logic [63:0] prod_fast;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] ext_a;
  logic [63:0] ext_b;

  assign ext_a     = {{32{a_neg}}, a};
  assign ext_b     = {{32{b_neg}}, b};
  assign prod_fast = ext_a * ext_b;
  assign fast_mul  = ~op[1];
`else
  assign prod_fast = 64'd0;
  assign fast_mul  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= StIdle;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hilo     <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (hilo_we) hilo <= hilo_wdata;
          if (start && fast_mul) begin
            // Result overrides a same-edge direct write.
            hilo <= prod_fast;
            done <= 1'b1;
          end else if (start) begin
            cnt      <= 5'd0;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= (b == 32'd0);
            opnd     <= op[1] ? abs_b : abs_a;
            acc      <= op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
            busy     <= 1'b1;
            state    <= op[1] ? StDiv : StMul;
          end
        end
        StMul: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            acc <= mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              hilo  <= mul_res;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
        StDiv: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            acc <= div_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              if (!div_zero) hilo <= {rem_res, quo_res};
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo. Expected results are pushed when an
// operation is launched and popped when done is observed.

module tb_mdu_hilo;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic [63:0] hilo;

  mdu_hilo dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .done       (done),
    .hilo       (hilo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] sb[$];
  logic [63:0] model_hilo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference results from plain wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa  = {{32{ma[31]}}, ma};
    sbv = {{32{mb[31]}}, mb};
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    case (mop)
      2'b00:   model = sa * sbv;
      2'b01:   model = ua * ub;
      2'b10: begin
        q = sa / sbv;
        r = sa % sbv;
        model = {r[31:0], q[31:0]};
      end
      default: model = {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Launch one operation and check its latency and result. disturb pulses start
  // and hilo_we mid-flight; we_start writes hilo on the accepting edge.
  task automatic run_op(input string tag, input logic [1:0] rop, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [63:0] exp, input bit disturb,
                        input bit we_start, input logic [63:0] wd);
    int cyc;
    int lat;
    logic [63:0] got_exp;
`ifdef MDU_FAST_MUL_EN
    lat = rop[1] ? 32 : 0;
`else
    lat = 32;
`endif
    @(negedge clk);
    start = 1'b1; op = rop; a = ra; b = rb;
    hilo_we = we_start; hilo_wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0; hilo_we = 1'b0;
    sb.push_back(exp);
    if (we_start) begin
      check({tag, "_we_at_start"}, hilo, wd);
      model_hilo = wd;
    end
    if (lat != 0) check({tag, "_busy_t0"}, {63'd0, busy}, 64'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (disturb && cyc == 5) begin
        @(negedge clk);
        start = 1'b1; op = ~rop; a = 32'h1234_5678; b = 32'h0000_0003;
        hilo_we = 1'b1; hilo_wdata = 64'hDEAD_BEEF_CAFE_F00D;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (disturb && cyc == 6) begin
        start = 1'b0; hilo_we = 1'b0;
        check({tag, "_busy_ignore"}, hilo, model_hilo);
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    got_exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    check({tag, "_hilo"}, hilo, got_exp);
    model_hilo = got_exp;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic hilo_write(input logic [63:0] wd);
    @(negedge clk);
    hilo_we = 1'b1; hilo_wdata = wd;
    @(posedge clk);
    #1;
    hilo_we = 1'b0;
    check("direct_write", hilo, wd);
    model_hilo = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    resetn = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    cancel = 1'b0; hilo_we = 1'b0; hilo_wdata = 64'd0;
    model_hilo = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", hilo, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
           0, 0, 0);
    run_op("mult_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001,
           0, 0, 0);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0);
    run_op("divu_100by7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0, 0);

    hilo_write(64'h1111_1111_2222_2222);
    run_op("divu_by0", 2'b11, 32'd1234, 32'd0, model_hilo, 0, 0, 0);

    // Cancel at cycle 10 of a DIVU.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_done", {63'd0, done}, 64'd0);
    check("cancel_hilo", hilo, model_hilo);

    // Start in the cycle after cancel, with start/hilo_we pulsed while busy.
    run_op("after_cancel", 2'b10, 32'd1000, 32'hFFFF_FFFD, model(2'b10, 32'd1000, 32'hFFFF_FFFD),
           1, 0, 0);

    // Direct write on the same edge a divide is accepted.
    run_op("we_with_start", 2'b11, 32'd77, 32'd5, model(2'b11, 32'd77, 32'd5), 0, 1,
           64'hAAAA_5555_0F0F_F0F0);

    // Most negative dividend by -1.
    run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0, 0, 0);
    end

    // Asynchronous reset at cycle 15 of a DIV.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd999; b = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_busy", {63'd0, busy}, 64'd0);
    check("areset_done", {63'd0, done}, 64'd0);
    check("areset_hilo", hilo, 64'd0);
    model_hilo = 64'd0;
    @(negedge clk);
    resetn = 1'b1;
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 64'd42, 0, 0, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit and HI/LO register pair for the MIPS core. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the 64-bit HI/LO state. It also accepts MTHI/MTLO write-back from the ALU, and it drives the `hilo` value that the ALU consumes for MFHI/MFLO/MTHI/MTLO. It sits beside the ALU in the execute stage; the pipeline stalls while `busy` is high.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: launch an operation; sampled only when `busy`=0.
- `op` in 2: operation code. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in 32: rs operand (multiplicand / dividend).
- `b` in 32: rt operand (multiplier / divisor).
- `cancel` in 1: pipeline flush; aborts the in-flight operation.
- `hilo_we` in 1: direct HI/LO write (MTHI/MTLO result from the ALU).
- `hilo_wdata` in 64: value for the direct write, {HI, LO}.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; `hilo` holds a new mul/div result.
- `hilo` out 64: current {HI, LO} register contents.

## Operation
- States:
  - IDLE: no operation in flight.
  - MUL: shift-add multiply in progress.
  - DIV: restoring divide in progress.
- Iteration counter is 5 bits, counting 0..31.
- IDLE, `start`=1 at an edge:
  - Latch |a| and |b| for signed ops; raw values for unsigned ops.
  - Latch result-sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31]. Flags are 0 for unsigned ops.
  - Clear the counter and enter MUL or DIV.
- MUL: each cycle, if multiplier LSB=1 add the multiplicand into the upper half of the 64-bit accumulator; then shift the accumulator right by 1 (33-bit add, carry kept).
- DIV: each cycle, shift the {remainder, quotient} 64-bit register left by 1 and trial-subtract the divisor from the upper 33 bits.
  - No borrow: keep the difference and set quotient bit 0.
  - Borrow: restore and clear quotient bit 0.
- Counter=31 edge, commit to `hilo` and return to IDLE:
  - MUL: `hilo` = product, two's-complement negated if the sign flag is set.
  - DIV: HI = remainder, LO = quotient, each negated per its own sign flag.
- Divide by zero (b=0 at start): the operation still runs the full 32 cycles and pulses `done`, but `hilo` is left unchanged.
- `cancel`=1 while busy: return to IDLE at the next edge; `hilo` unchanged, no `done`. `cancel` in IDLE has no effect.
- `start` while busy is ignored. `op`/`a`/`b` are ignored except at the accepting edge.
- `hilo_we`:
  - In IDLE: `hilo` is loaded with `hilo_wdata`, including on the same edge a `start` is accepted.
  - While busy: ignored.
  - On the commit edge: the mul/div result wins.
- Reset (asynchronous, any time including mid-operation): state IDLE, counter 0, `hilo`=0, `busy`=0, `done`=0. Any in-flight operation is discarded.

## Timing
- `start` accepted at edge T0. `busy`=1 during the 32 cycles after T0. Commit at edge T32. `busy`=0 and `done`=1 during the cycle after T32.
- Start-to-result latency: 32 cycles. Back-to-back: a new `start` is accepted at edge T32+1 at the earliest.
- `busy` and `done` are registered outputs. `hilo` is a register output with no combinational path from any input.
- `done` is never high at the same time as `busy`.

## Configuration
- Macro `MDU_FAST_MUL_EN`.
- Defined: MULT/MULTU complete combinationally in a single cycle.
  - `hilo` is written with the full 64-bit (signed or unsigned) product at edge T0.
  - `busy` never asserts for multiplies; `done` pulses in the cycle after T0.
  - DIV/DIVU are unchanged.
- Undefined: multiplies use the 32-cycle MUL state described above.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5.
  - Iterative build: `done` 33 cycles after `start` and `hilo`=0xFFFFFFFF_FFFFFFF1.
  - Fast build: `done` 1 cycle after `start`, same `hilo` value.
- MULTU a=b=0xFFFFFFFF -> `hilo`=0xFFFFFFFE_00000001. Repeat with MULT on the same operands -> `hilo`=0x00000000_00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- Preload `hilo`=0x11111111_22222222 via `hilo_we`, then DIVU by b=0 -> `done` pulses and `hilo` is unchanged.
- Launch DIVU, assert `cancel` at cycle 10 -> `busy` drops at the next edge, no `done`, `hilo` unchanged. Next, assert `hilo_we` while busy -> ignored. Next, a `start` issued in the cycle after `cancel` is accepted.
- Deassert `resetn` mid-DIV at cycle 15 -> `busy`, `done` and `hilo` go to 0 immediately (asynchronously). After release, a fresh MULTU 6×7 gives `hilo`=42.
